memory_register_ctrl: RTL and testbench

Parametrised memory address/data register pair (MAR/MDR) with a request/acknowledge bus controller. It sits between the CPU datapath and data memory. It latches a CPU-issued address, write data and direction, then drives one memory transaction and holds the memory side stable until the memory acknowledges. It returns read data or an error to the CPU, generalising the fixed 32-bit data / 16-bit address register to configurable widths with real transaction sequencing.

---
 rtl/memreg_pkg.sv | 13 +
 rtl/memreg_timeout.sv | 28 ++
 rtl/memory_register_ctrl.sv | 155 +++++++++++++++
 tb/tb_memory_register_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/memreg_pkg.sv
// Shared types and default sizing for the MAR/MDR memory bus controller.
package memreg_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int DEF_DATA_W      = 32;
    localparam int DEF_ADDR_W      = 16;
    localparam int DEF_TIMEOUT_CYC = 15;

endpackage

// File: rtl/memreg_timeout.sv
// Saturating BUSY-cycle counter; hit is high while the count equals MAX_CYC.
module memreg_timeout #(
    parameter int MAX_CYC = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic hit
);

    localparam int CNT_W = $clog2(MAX_CYC + 1);

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (en && (cnt_reg != CNT_W'(MAX_CYC))) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign hit = (cnt_reg == CNT_W'(MAX_CYC));

endmodule

// File: rtl/memory_register_ctrl.sv
// MAR/MDR register pair with a single-transaction req/ack memory bus controller.
// Optional BUSY timeout abort is built only when MEMREG_TIMEOUT_EN is defined.
module memory_register_ctrl
    import memreg_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_busy,
    output logic              cpu_done,
    output logic              cpu_err,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    generate
        if (TIMEOUT_CYC < 1) begin : g_param_check
            $error("TIMEOUT_CYC must be at least 1");
        end
    endgenerate

    state_t            state_reg, state_next;
    logic              mem_req_reg, mem_req_next;
    logic              mem_we_reg, mem_we_next;
    logic [ADDR_W-1:0] mar_reg, mar_next;
    logic [DATA_W-1:0] mdr_reg, mdr_next;
    logic              busy_reg, busy_next;
    logic              done_reg, done_next;
    logic [DATA_W-1:0] rdata_reg, rdata_next;
    logic              accept;

`ifdef MEMREG_TIMEOUT_EN
    logic err_reg, err_next;
    logic timeout_hit;

    memreg_timeout #(
        .MAX_CYC(TIMEOUT_CYC)
    ) u_timeout (
        .clk   (clk),
        .reset (reset),
        .clr   (accept),
        .en    ((state_reg == BUSY) && !mem_ack),
        .hit   (timeout_hit)
    );
`endif

    always_comb begin
        state_next   = state_reg;
        mem_req_next = mem_req_reg;
        mem_we_next  = mem_we_reg;
        mar_next     = mar_reg;
        mdr_next     = mdr_reg;
        busy_next    = busy_reg;
        done_next    = 1'b0;
        rdata_next   = rdata_reg;
        accept       = 1'b0;
`ifdef MEMREG_TIMEOUT_EN
        err_next     = 1'b0;
`endif
        case (state_reg)
            IDLE: begin
                if (cpu_req) begin
                    accept       = 1'b1;
                    mar_next     = cpu_addr;
                    mdr_next     = cpu_wdata;
                    mem_we_next  = cpu_we;
                    mem_req_next = 1'b1;
                    busy_next    = 1'b1;
                    state_next   = BUSY;
                end
            end
            BUSY: begin
                // An ack arriving on the timeout cycle still completes normally.
                if (mem_ack) begin
                    if (!mem_we_reg) begin
                        rdata_next = mem_rdata;
                    end
                    mem_req_next = 1'b0;
                    busy_next    = 1'b0;
                    done_next    = 1'b1;
                    state_next   = IDLE;
                end
`ifdef MEMREG_TIMEOUT_EN
                else if (timeout_hit) begin
                    mem_req_next = 1'b0;
                    busy_next    = 1'b0;
                    done_next    = 1'b1;
                    err_next     = 1'b1;
                    state_next   = IDLE;
                end
`endif
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            mem_req_reg <= 1'b0;
            mem_we_reg  <= 1'b0;
            mar_reg     <= '0;
            mdr_reg     <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            rdata_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            mem_req_reg <= mem_req_next;
            mem_we_reg  <= mem_we_next;
            mar_reg     <= mar_next;
            mdr_reg     <= mdr_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
            rdata_reg   <= rdata_next;
        end
    end

`ifdef MEMREG_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_reg <= 1'b0;
        end else begin
            err_reg <= err_next;
        end
    end

    assign cpu_err = err_reg;
`else
    assign cpu_err = 1'b0;
`endif

    assign cpu_busy  = busy_reg;
    assign cpu_done  = done_reg;
    assign cpu_rdata = rdata_reg;
    assign mem_req   = mem_req_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mar_reg;
    assign mem_wdata = mdr_reg;

endmodule

// File: tb/tb_memory_register_ctrl.sv
// Scoreboard bench for memory_register_ctrl: stimulus queues expected bus requests
// and completions; a negedge monitor pops and compares them as the DUT presents them.
module tb_memory_register_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_busy;
    logic        cpu_done;
    logic        cpu_err;
    logic [31:0] cpu_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int total = 0;
    int bad   = 0;

    logic [48:0] req_q[$];   // {we, addr, wdata}
    logic [32:0] done_q[$];  // {err, rdata}
    logic [31:0] model_rdata;

    memory_register_ctrl #(
        .DATA_W      (32),
        .ADDR_W      (16),
        .TIMEOUT_CYC (15)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_busy  (cpu_busy),
        .cpu_done  (cpu_done),
        .cpu_err   (cpu_err),
        .cpu_rdata (cpu_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Monitor: compares each new bus request and each completion against the queues.
    logic mem_req_prev = 1'b0;
    logic done_prev    = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            mem_req_prev = 1'b0;
            done_prev    = 1'b0;
        end else begin
            if (mem_req && !mem_req_prev) begin
                if (req_q.size() == 0) begin
                    chk("unexpected_req", {15'd0, mem_we, mem_addr, mem_wdata}, 64'd0);
                end else begin
                    chk("mem_req_fields", {15'd0, mem_we, mem_addr, mem_wdata}, {15'd0, req_q.pop_front()});
                    chk("busy_with_req", {63'd0, cpu_busy}, 64'd1);
                end
            end
            if (cpu_done) begin
                chk("done_one_cycle", {63'd0, done_prev}, 64'd0);
                if (done_q.size() == 0) begin
                    chk("unexpected_done", {31'd0, cpu_err, cpu_rdata}, 64'd0);
                end else begin
                    chk("done_err_rdata", {31'd0, cpu_err, cpu_rdata}, {31'd0, done_q.pop_front()});
                end
            end
            mem_req_prev = mem_req;
            done_prev    = cpu_done;
        end
    end

    // Called at posedge+1; issues a request, acks after ack_dly extra cycles, and
    // returns at posedge+1 of the cycle in which cpu_done is expected high.
    task automatic do_txn(input logic we, input logic [15:0] addr, input logic [31:0] wdata,
                          input int ack_dly, input logic [31:0] rdata);
        req_q.push_back({we, addr, wdata});
        if (!we) model_rdata = rdata;
        done_q.push_back({1'b0, model_rdata});
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        @(posedge clk); #1;
        cpu_req = 1'b0;
        repeat (ack_dly) begin
            @(posedge clk); #1;
        end
        mem_ack   = 1'b1;
        mem_rdata = rdata;
        @(posedge clk); #1;
        mem_ack   = 1'b0;
        mem_rdata = 32'h5A5A_5A5A;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0; model_rdata = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_outputs",
            {cpu_busy, cpu_done, cpu_err, mem_req, mem_we, mem_addr, mem_wdata[15:0], cpu_rdata[15:0]}, 64'd0);
        chk("reset_wide", {cpu_rdata, mem_wdata}, 64'd0);
        @(posedge clk); #1;

        // Write with minimum latency: cpu_rdata must stay 0.
        do_txn(1'b1, 16'd4, 32'hACED_CAFE, 0, 32'h1111_1111);
        idle_cycles(1);
        // Read, ack after 3 cycles.
        do_txn(1'b0, 16'd3, 32'h0, 3, 32'hDEAD_BEEF);
        idle_cycles(2);
        // Write while memory drives data: rdata untouched.
        do_txn(1'b1, 16'd7, 32'h0102_0304, 2, 32'h1234_5678);
        idle_cycles(1);

        // mem_ack in IDLE must be ignored.
        mem_ack = 1'b1; mem_rdata = 32'hFFFF_0000;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        idle_cycles(2);
        chk("idle_ack_rdata", {32'd0, cpu_rdata}, {32'd0, model_rdata});

        // cpu_req held into BUSY with a different address is ignored.
        req_q.push_back({1'b1, 16'h0040, 32'h0BAD_F00D});
        done_q.push_back({1'b0, model_rdata});
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0040; cpu_wdata = 32'h0BAD_F00D;
        @(posedge clk); #1;
        cpu_addr = 16'h0041; cpu_wdata = 32'h7777_7777; cpu_we = 1'b0;
        @(posedge clk); #1;
        cpu_req = 1'b0;
        chk("busy_req_ignored", {16'd0, mem_addr, mem_wdata}, {16'd0, 16'h0040, 32'h0BAD_F00D});
        mem_ack = 1'b1;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        idle_cycles(3);
        chk("idle_after_ignore", {62'd0, mem_req, cpu_busy}, 64'd0);

        // Back-to-back: each new request issued in the cpu_done cycle.
        do_txn(1'b0, 16'h0010, 32'h0, 1, 32'h1111_2222);
        chk("b2b_done_high", {63'd0, cpu_done}, 64'd1);
        do_txn(1'b0, 16'h0020, 32'h0, 0, 32'h3333_4444);
        do_txn(1'b1, 16'h0030, 32'h9999_8888, 0, 32'h0);
        idle_cycles(2);

`ifdef MEMREG_TIMEOUT_EN
        // No ack: abort with error exactly 16 cycles after mem_req rises.
        req_q.push_back({1'b0, 16'h0077, 32'h0});
        done_q.push_back({1'b1, model_rdata});
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0077; cpu_wdata = 32'h0;
        @(posedge clk); #1;
        cpu_req = 1'b0;
        idle_cycles(15);
        chk("timeout_not_early", {62'd0, cpu_done, mem_req}, 64'd1);
        idle_cycles(1);
        chk("timeout_abort", {61'd0, cpu_done, cpu_err, mem_req}, 64'd6);
        idle_cycles(2);
        // Ack on the timeout cycle wins.
        do_txn(1'b0, 16'h0078, 32'h0, 15, 32'hFEED_F00D);
        idle_cycles(2);
`else
        // Without the timeout, a slow ack still completes normally.
        do_txn(1'b0, 16'h0078, 32'h0, 20, 32'hFEED_F00D);
        idle_cycles(2);
`endif

        // Asynchronous reset mid-BUSY, then a normal transaction.
        req_q.push_back({1'b1, 16'h0050, 32'h5555_AAAA});
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0050; cpu_wdata = 32'h5555_AAAA;
        @(posedge clk); #1;
        cpu_req = 1'b0;
        idle_cycles(2);
        chk("busy_before_reset", {62'd0, mem_req, cpu_busy}, 64'd3);
        #2 reset = 1'b1;
        #1;
        chk("async_reset_drop", {62'd0, mem_req, cpu_busy}, 64'd0);
        model_rdata = '0;
        @(posedge clk); #1;
        reset = 1'b0;
        idle_cycles(1);
        chk("rdata_after_reset", {32'd0, cpu_rdata}, 64'd0);
        do_txn(1'b0, 16'h0055, 32'h0, 0, 32'hCAFE_F00D);
        idle_cycles(3);

        chk("queues_drained", {32'(req_q.size()), 32'(done_q.size())}, 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
